riscv_core_dcache_writeback_buffer: RTL and testbench
=====================================================

// Module: riscv_core_dcache_writeback_buffer
// PURPOSE
//  Write-back path for evicted dirty D-cache blocks; counterpart of the refill path into the data memory.
//  Cache controller pushes {block address, 256-bit block}; the buffer queues it and drives an AXI4 write:
//  single-beat burst, one AW, one W, one B per block. Address lookup lets the controller stall a refill
//  that would fetch a stale line still queued here.
// PARAMETERS
//  ADDR_WIDTH      64   byte address width
//  AXI_DATA_WIDTH  256  block width = AXI W data width (32 B line)
//  DEPTH           4    queued blocks, power of 2, >=2
//  LINE_LSB        5    log2(line bytes); address bits below are zero on AWADDR
// PORTS
//  i_clk           in   1    clock
//  i_rst           in   1    synchronous, active-high reset
//  i_evict_valid   in   1    controller offers an evicted block
//  o_evict_ready   out  1    buffer can accept (= !full)
//  i_evict_addr    in   ADDR_WIDTH      any address inside the evicted line
//  i_evict_block   in   AXI_DATA_WIDTH  line data, byte 0 in bits [7:0]
//  i_lookup_addr   in   ADDR_WIDTH      refill address to check
//  o_lookup_hit    out  1    line of i_lookup_addr is queued or in flight
//  o_awvalid/i_awready  out/in 1  AW handshake
//  o_awaddr        out  ADDR_WIDTH  line-aligned address
//  o_awlen/o_awsize/o_awburst out 8/3/2  constant 0 / 3'b101 / 2'b01 (INCR)
//  o_wvalid/i_wready    out/in 1  W handshake
//  o_wdata         out  AXI_DATA_WIDTH  head entry block
//  o_wstrb/o_wlast out  AXI_DATA_WIDTH/8 / 1  constant all-ones / 1
//  i_bvalid/o_bready    in/out 1  B handshake
//  i_bresp         in   2    write response
//  o_empty         out  1    no entry queued or in flight
//  o_err           out  1    sticky: some B returned SLVERR/DECERR
// BEHAVIOUR
//  Reset: pointers/count 0, FSM IDLE, o_awvalid=o_wvalid=o_bready=0, o_evict_ready=1, o_empty=1,
//   o_lookup_hit=0, o_err=0. Storage contents not reset. Reset mid-transaction abandons it (system resets
//   interconnect simultaneously).
//  Push: i_evict_valid && o_evict_ready at edge t writes tail; entry visible from t+1. o_evict_ready = !full
//   only; push when full is refused even if a pop completes that same cycle (no bypass).
//  Entry freed (pop) only on B handshake; head stays valid, and hit-visible, until then.
//  FSM IDLE: !empty -> SEND (head visible at t+1, so AW/W valid from t+2 for a push into an empty buffer).
//  SEND: o_awvalid = !aw_done, o_wvalid = !w_done; AW and W independent, either order or same cycle;
//   done flags set on handshake. Both done (incl. same-cycle completion) -> RESP, flags cleared.
//  RESP: o_bready=1; on i_bvalid pop head; bresp[1]=1 sets o_err; -> SEND if count after pop >0, else IDLE.
//  Once asserted, AW/W valid and payload hold until handshake (AXI stability).
//  Lookup (comb): hit if any valid entry has addr[ADDR_WIDTH-1:LINE_LSB] == i_lookup_addr[ADDR_WIDTH-1:LINE_LSB].
//  Simultaneous push and pop: count unchanged, both pointers advance, wrap modulo DEPTH.
//  o_empty = (count==0); o_err cleared only by reset.
// STRUCTURE
//  riscv_core_dcache_pkg: wb_state_e {IDLE,SEND,RESP}, AXI_BURST_INCR, AXI_RESP_* constants, LINE_LSB.
//  One sub-module: riscv_core_sync_fifo (param width/depth, push/pop, full/empty, per-entry valid + data
//  exposed for lookup); FSM, AXI mapping and compare logic stay in this module.
// TESTING
//  Push addr 0x1000_0047, block 0xA5.. ; awready/wready=1, bvalid 2 cyc later -> awaddr 0x1000_0040, wdata match, one B, o_empty=1.
//  wready 3 cyc before awready, then reverse -> each valid held till own handshake; exactly one AW,one W.
//  Push 4 blocks, hold awready=0 -> o_evict_ready=0 after 4th; 5th refused; B completes -> ready=1 next cycle.
//  Fill to 4, then push+pop same cycle repeatedly across wrap -> AXI order = push order, count stays correct.
//  Queue line 0x2000; lookup 0x2018 -> hit=1, 0x2020 -> hit=0; hit drops cycle after that B.
//  bresp=2'b10 on 2nd of 3 blocks -> o_err=1 stays set, 3rd still sent; i_rst mid-SEND -> all outputs reset values.

Source files
------------

// File: rtl/riscv_core_dcache_pkg.sv
// Shared constants for the D-cache write-back path: AXI encodings, line geometry and the
// write-back FSM state encoding.
package riscv_core_dcache_pkg;

  localparam int unsigned LINE_LSB = 5;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef logic [1:0] wb_state_e;
  localparam wb_state_e WB_IDLE = 2'd0;
  localparam wb_state_e WB_SEND = 2'd1;
  localparam wb_state_e WB_RESP = 2'd2;

endpackage

// File: rtl/riscv_core_sync_fifo.sv
// Synchronous FIFO with per-entry valid bits and raw storage exposed so the owner can
// search queued entries. Push is refused when full, regardless of a same-cycle pop.
module riscv_core_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic [Width-1:0]             head_o,
  output logic [Depth-1:0]             valid_o,
  output logic [Depth-1:0][Width-1:0]  entries_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [Depth-1:0]           valid_q, valid_d;
  logic [Depth-1:0][Width-1:0] mem_q;
  logic                       push_en, pop_en;

  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign valid_o   = valid_q;
  assign entries_o = mem_q;

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // Depth is a power of two, so pointer arithmetic wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_en);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_en);
    count_d  = count_q + CntW'(push_en) - CntW'(pop_en);
    valid_d  = valid_q;
    if (pop_en)  valid_d[rd_ptr_q] = 1'b0;
    if (push_en) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_core_dcache_writeback_buffer.sv
// Queues evicted dirty D-cache lines and writes each back as a single-beat AXI4 burst;
// also reports whether a refill address hits a line still queued or in flight.
module riscv_core_dcache_writeback_buffer #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned AXI_DATA_WIDTH = 256,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LINE_LSB       = riscv_core_dcache_pkg::LINE_LSB
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_evict_valid,
  output logic                          o_evict_ready,
  input  logic [ADDR_WIDTH-1:0]         i_evict_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     i_evict_block,
  input  logic [ADDR_WIDTH-1:0]         i_lookup_addr,
  output logic                          o_lookup_hit,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [ADDR_WIDTH-1:0]         o_awaddr,
  output logic [7:0]                    o_awlen,
  output logic [2:0]                    o_awsize,
  output logic [1:0]                    o_awburst,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wlast,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  input  logic [1:0]                    i_bresp,
  output logic                          o_empty,
  output logic                          o_err
);
  import riscv_core_dcache_pkg::*;

  localparam int unsigned TagW   = ADDR_WIDTH - LINE_LSB;
  localparam int unsigned EntryW = TagW + AXI_DATA_WIDTH;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  wb_state_e                     state_q, state_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          err_q, err_d;
  logic                          pop;
  logic                          push_fire, aw_hs, w_hs;
  logic                          fifo_full, fifo_empty;
  logic [CntW-1:0]               fifo_count;
  logic [EntryW-1:0]             fifo_head;
  logic [DEPTH-1:0]              fifo_valid;
  logic [DEPTH-1:0][EntryW-1:0]  fifo_entries;
  logic                          unused_bits;

  riscv_core_sync_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .push_i    (i_evict_valid),
    .data_i    ({i_evict_addr[ADDR_WIDTH-1:LINE_LSB], i_evict_block}),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .head_o    (fifo_head),
    .valid_o   (fifo_valid),
    .entries_o (fifo_entries)
  );

  assign o_evict_ready = !fifo_full;
  assign push_fire     = i_evict_valid && !fifo_full;
  assign o_empty       = fifo_empty;
  assign o_err         = err_q;

  assign o_awvalid = (state_q == WB_SEND) && !aw_done_q;
  assign o_wvalid  = (state_q == WB_SEND) && !w_done_q;
  assign o_bready  = (state_q == WB_RESP);
  assign aw_hs     = o_awvalid && i_awready;
  assign w_hs      = o_wvalid && i_wready;

  assign o_awaddr  = {fifo_head[EntryW-1:AXI_DATA_WIDTH], {LINE_LSB{1'b0}}};
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_awburst = AXI_BURST_INCR;
  assign o_wdata   = fifo_head[AXI_DATA_WIDTH-1:0];
  assign o_wstrb   = '1;
  assign o_wlast   = 1'b1;

  assign unused_bits = ^{i_evict_addr[LINE_LSB-1:0], i_lookup_addr[LINE_LSB-1:0], i_bresp[0]};

  always_comb begin
    o_lookup_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (fifo_valid[i] &&
          fifo_entries[i][EntryW-1:AXI_DATA_WIDTH] == i_lookup_addr[ADDR_WIDTH-1:LINE_LSB]) begin
        o_lookup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    pop       = 1'b0;
    case (state_q)
      WB_IDLE: if (!fifo_empty) state_d = WB_SEND;
      WB_SEND: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WB_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WB_RESP: begin
        if (i_bvalid) begin
          pop = 1'b1;
          if (i_bresp[1]) err_d = 1'b1;
          // Occupancy after this pop, counting a push landing in the same cycle.
          state_d = (fifo_count > CntW'(1) || push_fire) ? WB_SEND : WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WB_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_dcache_writeback_buffer.sv
// Scoreboard bench for the D-cache write-back buffer: directed pushes queue expected AW/W
// payloads; a negedge monitor compares every handshake and checks AXI payload stability.
module tb_riscv_core_dcache_writeback_buffer;
  localparam int AW = 64;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            evict_valid;
  logic            evict_ready;
  logic [AW-1:0]   evict_addr;
  logic [DW-1:0]   evict_block;
  logic [AW-1:0]   lookup_addr;
  logic            lookup_hit;
  logic            awvalid, awready;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            wvalid, wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            bvalid, bready;
  logic [1:0]      bresp;
  logic            empty, err;

  always #5 clk = ~clk;

  riscv_core_dcache_writeback_buffer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_evict_valid (evict_valid),
    .o_evict_ready (evict_ready),
    .i_evict_addr  (evict_addr),
    .i_evict_block (evict_block),
    .i_lookup_addr (lookup_addr),
    .o_lookup_hit  (lookup_hit),
    .o_awvalid     (awvalid),
    .i_awready     (awready),
    .o_awaddr      (awaddr),
    .o_awlen       (awlen),
    .o_awsize      (awsize),
    .o_awburst     (awburst),
    .o_wvalid      (wvalid),
    .i_wready      (wready),
    .o_wdata       (wdata),
    .o_wstrb       (wstrb),
    .o_wlast       (wlast),
    .i_bvalid      (bvalid),
    .o_bready      (bready),
    .i_bresp       (bresp),
    .o_empty       (empty),
    .o_err         (err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_issued = 0;
  bit b_taken = 1'b0;
  bit b_auto = 1'b1;
  logic [1:0] bresp_plan [int];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: samples mid-cycle; a handshake seen here completes at the next rising edge.
  bit prev_aw_pend = 1'b0, prev_w_pend = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;
  always @(negedge clk) begin
    if (rst) begin
      prev_aw_pend = 1'b0;
      prev_w_pend  = 1'b0;
    end else begin
      if (prev_aw_pend) begin
        check("aw_hold_valid", awvalid, 1'b1);
        check("aw_hold_addr", awaddr, prev_awaddr);
      end
      if (prev_w_pend) begin
        check("w_hold_valid", wvalid, 1'b1);
        check("w_hold_data", wdata, prev_wdata);
      end
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          check("awaddr", awaddr, exp_aw_q.pop_front());
          check("aw_const", {awlen, awsize, awburst}, {8'd0, 3'b101, 2'b01});
        end
        aw_cnt++;
      end
      if (wvalid && wready) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else begin
          check("wdata", wdata, exp_w_q.pop_front());
          check("w_const", {&wstrb, wlast}, 2'b11);
        end
        w_cnt++;
      end
      if (bvalid && bready) begin
        b_cnt++;
        b_taken = 1'b1;
      end
      prev_aw_pend = awvalid && !awready;
      prev_awaddr  = awaddr;
      prev_w_pend  = wvalid && !wready;
      prev_wdata   = wdata;
    end
  end

  // B responder: one response per block whose AW and W both completed, two cycles later.
  int b_delay = 0;
  initial begin
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bvalid  = 1'b0;
        b_delay = 0;
      end else begin
        if (bvalid && b_taken) begin
          bvalid  = 1'b0;
          b_taken = 1'b0;
        end
        if (!bvalid && b_auto && ((aw_cnt < w_cnt ? aw_cnt : w_cnt) > b_issued)) begin
          b_delay++;
          if (b_delay >= 2) begin
            bvalid   = 1'b1;
            bresp    = bresp_plan.exists(b_issued) ? bresp_plan[b_issued] : 2'b00;
            b_issued++;
            b_delay  = 0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] blk);
    bit done = 1'b0;
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_block = blk;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (evict_ready) begin
        exp_aw_q.push_back({a[AW-1:5], 5'b0});
        exp_w_q.push_back(blk);
        done = 1'b1;
      end
      step(1);
    end
    evict_valid = 1'b0;
    if (!done) fail_now("push_timeout");
  endtask

  task automatic wait_empty(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (empty && exp_aw_q.size() == 0) seen = 1'b1;
    end
    if (!seen) fail_now("drain_timeout");
    step(1);
  endtask

  task automatic clear_bench();
    exp_aw_q.delete();
    exp_w_q.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_issued = 0;
    b_taken = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_evict_ready"}, evict_ready, 1'b1);
    check({tag, "_empty"}, empty, 1'b1);
    check({tag, "_awvalid"}, awvalid, 1'b0);
    check({tag, "_wvalid"}, wvalid, 1'b0);
    check({tag, "_bready"}, bready, 1'b0);
    check({tag, "_hit"}, lookup_hit, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    int base_aw, base_w, base_b;
    bit found;
    rst = 1'b1;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_block = '0;
    lookup_addr = '0;
    awready = 1'b1;
    wready  = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    step(1);

    // Basic write-back: address aligned, one AW/W/B.
    push(64'h1000_0047, {32{8'hA5}});
    @(negedge clk);
    check("t1_no_early_aw", awvalid, 1'b0);
    step(1);
    wait_empty(50);
    check("t1_aw_count", aw_cnt, 1);
    check("t1_w_count", w_cnt, 1);
    check("t1_b_count", b_cnt, 1);
    check("t1_empty", empty, 1'b1);

    // W accepted first, then AW first.
    base_aw = aw_cnt; base_w = w_cnt;
    awready = 1'b0; wready = 1'b0;
    push(64'h1000_0100, pat(32'h1111_2222));
    step(2);
    wready = 1'b1;
    step(1);
    @(negedge clk);
    check("t2_w_dropped", wvalid, 1'b0);
    check("t2_aw_held", awvalid, 1'b1);
    step(2);
    awready = 1'b1;
    wait_empty(50);
    awready = 1'b0; wready = 1'b0;
    push(64'h1000_0200, pat(32'h3333_4444));
    step(2);
    awready = 1'b1;
    step(1);
    @(negedge clk);
    check("t2_aw_dropped", awvalid, 1'b0);
    check("t2_w_held", wvalid, 1'b1);
    step(2);
    wready = 1'b1;
    wait_empty(50);
    check("t2_aw_count", aw_cnt - base_aw, 2);
    check("t2_w_count", w_cnt - base_w, 2);

    // Full buffer refuses a push until a B frees an entry.
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'h3000_0000 + 64'(i) * 64'h40, pat(32'hF000_0000 + i));
    evict_valid = 1'b1;
    evict_addr  = 64'h3000_1000;
    evict_block = pat(32'h5555_AAAA);
    @(negedge clk);
    check("t3_full_not_ready", evict_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      @(negedge clk);
      check("t3_still_full", evict_ready, 1'b0);
    end
    step(1);
    awready = 1'b1; wready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin
        check("t3_ready_at_b", evict_ready, 1'b0);
        @(negedge clk);
        check("t3_ready_after_b", evict_ready, 1'b1);
        exp_aw_q.push_back(64'h3000_1000);
        exp_w_q.push_back(pat(32'h5555_AAAA));
        found = 1'b1;
      end
    end
    if (!found) fail_now("t3_b_timeout");
    step(1);
    evict_valid = 1'b0;
    wait_empty(100);

    // Streaming across pointer wrap with pushes overlapping pops.
    base_aw = aw_cnt;
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 4; i++) push(64'h4000_0000 + 64'(i) * 64'h20, pat(32'hC0DE_0000 + i));
    awready = 1'b1; wready = 1'b1;
    for (int i = 4; i < 10; i++) push(64'h4000_0000 + 64'(i) * 64'h20, pat(32'hC0DE_0000 + i));
    wait_empty(200);
    check("t4_aw_count", aw_cnt - base_aw, 10);
    check("t4_empty", empty, 1'b1);

    // Lookup hit on a queued line, dropping after its B.
    awready = 1'b0; wready = 1'b0;
    push(64'h2000, pat(32'h2000_2000));
    lookup_addr = 64'h2018;
    @(negedge clk);
    check("t5_hit_same_line", lookup_hit, 1'b1);
    step(1);
    lookup_addr = 64'h2020;
    @(negedge clk);
    check("t5_miss_next_line", lookup_hit, 1'b0);
    step(1);
    lookup_addr = 64'h2018;
    awready = 1'b1; wready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin
        check("t5_hit_at_b", lookup_hit, 1'b1);
        @(negedge clk);
        check("t5_hit_after_b", lookup_hit, 1'b0);
        found = 1'b1;
      end
    end
    if (!found) fail_now("t5_b_timeout");
    step(1);
    wait_empty(50);
    check("t5_err_clear", err, 1'b0);

    // Error response on the middle block: sticky error, third block still written.
    base_aw = aw_cnt; base_b = b_cnt;
    bresp_plan[b_issued + 1] = 2'b10;
    for (int i = 0; i < 3; i++) push(64'h5000_0000 + 64'(i) * 64'h20, pat(32'hE000_0000 + i));
    wait_empty(100);
    check("t6_err_sticky", err, 1'b1);
    check("t6_aw_count", aw_cnt - base_aw, 3);
    check("t6_b_count", b_cnt - base_b, 3);

    // Reset in the middle of SEND.
    awready = 1'b0; wready = 1'b0;
    push(64'h6000_0000, pat(32'h6666_6666));
    lookup_addr = 64'h6000_0000;
    step(2);
    @(negedge clk);
    check("t7_in_send", awvalid, 1'b1);
    step(1);
    rst = 1'b1;
    step(1);
    clear_bench();
    @(negedge clk);
    check_reset_outputs("t7_mid_reset");
    step(1);
    rst = 1'b0;
    awready = 1'b1; wready = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
